// File: rtl/pbox_context_sequencer.sv
// Steps a loadable context program into one predication box; conditional jumps use the box's same-cycle predicate.
// Loads are held off (ready low) while a program runs.
module pbox_context_sequencer #(
  parameter int CONTEXT_WIDTH = 16,
  parameter int ADDR_WIDTH    = 6,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                                CLK_I,
  input  logic                                RST_I,
  input  logic                                LOAD_VALID_I,
  output logic                                LOAD_READY_O,
  input  logic [ADDR_WIDTH-1:0]               LOAD_ADDR_I,
  input  logic [CONTEXT_WIDTH+ADDR_WIDTH+1:0] LOAD_DATA_I,
  input  logic                                START_I,
  input  logic [ADDR_WIDTH-1:0]               START_ADDR_I,
  input  logic                                ABORT_I,
  input  logic                                STALL_I,
  input  logic                                PBOX_COMB_I,
  output logic [CONTEXT_WIDTH-1:0]            CONTEXT_O,
  output logic                                EN_O,
  output logic [ADDR_WIDTH-1:0]               PC_O,
  output logic                                BUSY_O,
  output logic                                DONE_O,
  output logic [CNT_WIDTH-1:0]                CYCLE_CNT_O
);

  localparam int ENTRY_W = CONTEXT_WIDTH + ADDR_WIDTH + 2;
  localparam int DEPTH   = 2**ADDR_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [ENTRY_W-1:0]      r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0]   r_pc;
  logic [CNT_WIDTH-1:0]    r_cnt;

  logic [ENTRY_W-1:0]       w_entry;
  logic                     w_halt;
  logic                     w_branch;
  logic [ADDR_WIDTH-1:0]    w_target;
  logic [CONTEXT_WIDTH-1:0] w_ctx;
  logic                     w_load_fire;
  logic                     w_start;
  logic                     w_exec;

  // Entry layout: {halt, branch, target, context}
  assign w_entry  = r_mem[r_pc];
  assign w_halt   = w_entry[ENTRY_W-1];
  assign w_branch = w_entry[ENTRY_W-2];
  assign w_target = w_entry[CONTEXT_WIDTH +: ADDR_WIDTH];
  assign w_ctx    = w_entry[CONTEXT_WIDTH-1:0];

  assign w_load_fire = LOAD_VALID_I && (r_state != S_RUN);
  assign w_start     = START_I && !ABORT_I && (r_state != S_RUN);
  assign w_exec      = (r_state == S_RUN) && !STALL_I && !ABORT_I;

  // Memory is deliberately outside reset so programs survive RST_I.
  always_ff @(posedge CLK_I) begin
    if (w_load_fire) begin
      r_mem[LOAD_ADDR_I] <= LOAD_DATA_I;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (ABORT_I) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: if (START_I) w_next_state = S_RUN;
        S_RUN:          if (!STALL_I && w_halt) w_next_state = S_DONE;
        default:        w_next_state = S_IDLE;
      endcase
    end
  end

  always_comb begin
    LOAD_READY_O = 1'b1;
    BUSY_O       = 1'b0;
    DONE_O       = 1'b0;
    EN_O         = 1'b0;
    CONTEXT_O    = '0;
    case (r_state)
      S_RUN: begin
        LOAD_READY_O = 1'b0;
        BUSY_O       = 1'b1;
        EN_O         = !STALL_I;
        CONTEXT_O    = w_ctx;
      end
      S_DONE:  DONE_O = 1'b1;
      default: ;
    endcase
  end

  // Halt keeps PC on the halting entry; the halt cycle itself is counted.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_pc  <= '0;
      r_cnt <= '0;
    end else if (w_start) begin
      r_pc  <= START_ADDR_I;
      r_cnt <= '0;
    end else if (w_exec) begin
      if (r_cnt != '1) begin
        r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
      if (!w_halt) begin
        r_pc <= (w_branch && PBOX_COMB_I) ? w_target : r_pc + ADDR_WIDTH'(1);
      end
    end
  end

  assign PC_O        = r_pc;
  assign CYCLE_CNT_O = r_cnt;

endmodule

// File: tb/tb_pbox_context_sequencer.sv
// Directed program scenarios followed by random traffic, all checked every cycle against a program-level model.
module tb_pbox_context_sequencer;

  localparam int CW    = 16;
  localparam int AW    = 3;
  localparam int NW    = 4;
  localparam int DEPTH = 8;
  localparam int CMAX  = 15;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              load_valid;
  logic              load_ready;
  logic [AW-1:0]     load_addr;
  logic [CW+AW+1:0]  load_data;
  logic              start;
  logic [AW-1:0]     start_addr;
  logic              abort;
  logic              stall;
  logic              comb;
  logic [CW-1:0]     ctx;
  logic              en;
  logic [AW-1:0]     pc;
  logic              busy;
  logic              done;
  logic [NW-1:0]     cnt;

  logic              ld_halt;
  logic              ld_br;
  logic [AW-1:0]     ld_tgt;
  logic [CW-1:0]     ld_ctx;

  assign load_data = {ld_halt, ld_br, ld_tgt, ld_ctx};

  pbox_context_sequencer #(.CONTEXT_WIDTH(CW), .ADDR_WIDTH(AW), .CNT_WIDTH(NW)) dut (
    .CLK_I(clk), .RST_I(rst),
    .LOAD_VALID_I(load_valid), .LOAD_READY_O(load_ready),
    .LOAD_ADDR_I(load_addr), .LOAD_DATA_I(load_data),
    .START_I(start), .START_ADDR_I(start_addr),
    .ABORT_I(abort), .STALL_I(stall), .PBOX_COMB_I(comb),
    .CONTEXT_O(ctx), .EN_O(en), .PC_O(pc),
    .BUSY_O(busy), .DONE_O(done), .CYCLE_CNT_O(cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int m_mode, m_pc, m_cnt;
  int m_ctx [DEPTH];
  int m_tgt [DEPTH];
  bit m_halt [DEPTH];
  bit m_br [DEPTH];

  int obs_pc, obs_ctx, obs_cnt;
  bit obs_en, obs_done, obs_busy, obs_ready;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_update();
    int a;
    if (load_valid && m_mode != M_RUN) begin
      a = int'(load_addr);
      m_ctx[a]  = int'(ld_ctx);
      m_tgt[a]  = int'(ld_tgt);
      m_halt[a] = ld_halt;
      m_br[a]   = ld_br;
    end
    if (rst) begin
      m_mode = M_IDLE; m_pc = 0; m_cnt = 0;
    end else if (abort) begin
      m_mode = M_IDLE;
    end else if (m_mode != M_RUN && start) begin
      m_mode = M_RUN; m_pc = int'(start_addr); m_cnt = 0;
    end else if (m_mode == M_RUN && !stall) begin
      m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
      if (m_halt[m_pc])                m_mode = M_DONE;
      else if (m_br[m_pc] && comb)     m_pc = m_tgt[m_pc];
      else                             m_pc = (m_pc + 1) % DEPTH;
    end
  endtask

  task automatic step();
    int e_ctx;
    @(negedge clk);
    e_ctx = (m_mode == M_RUN) ? m_ctx[m_pc] : 0;
    check_eq("ready", load_ready, m_mode != M_RUN);
    check_eq("busy", busy, m_mode == M_RUN);
    check_eq("done", done, m_mode == M_DONE);
    check_eq("en", en, m_mode == M_RUN && !stall);
    check_eq("ctx", ctx, e_ctx);
    check_eq("pc", pc, m_pc);
    check_eq("cnt", cnt, m_cnt);
    obs_pc = int'(pc); obs_ctx = int'(ctx); obs_cnt = int'(cnt);
    obs_en = en; obs_done = done; obs_busy = busy; obs_ready = load_ready;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_entry(input int a, input bit h, input bit b, input int t, input int c);
    load_valid = 1'b1; load_addr = AW'(a);
    ld_halt = h; ld_br = b; ld_tgt = AW'(t); ld_ctx = CW'(c);
    step();
    load_valid = 1'b0;
  endtask

  task automatic kick(input int a);
    start = 1'b1; start_addr = AW'(a);
    step();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load_valid = 1'b0; load_addr = '0; start = 1'b0; start_addr = '0;
    abort = 1'b0; stall = 1'b0; comb = 1'b0;
    ld_halt = 1'b0; ld_br = 1'b0; ld_tgt = '0; ld_ctx = '0;
    m_mode = M_IDLE; m_pc = 0; m_cnt = 0;
    for (int i = 0; i < DEPTH; i++) begin
      m_ctx[i] = 0; m_tgt[i] = 0; m_halt[i] = 1'b0; m_br[i] = 1'b0;
    end
    @(posedge clk); model_update(); #1;
    step();
    check_eq("rst_pc", obs_pc, 0);
    check_eq("rst_cnt", obs_cnt, 0);
    check_eq("rst_busy", obs_busy, 0);
    check_eq("rst_done", obs_done, 0);
    rst = 1'b0;

    for (int i = 0; i < DEPTH; i++) set_entry(i, i == 3, 0, 0, 'h11 + i);

    // straight-line run
    kick(0);
    for (int k = 0; k < 4; k++) begin
      step();
      check_eq("sl_ctx", obs_ctx, 'h11 + k);
      check_eq("sl_en", obs_en, 1);
    end
    step();
    check_eq("sl_done", obs_done, 1);
    check_eq("sl_cnt", obs_cnt, 4);
    check_eq("sl_ctx_idle", obs_ctx, 0);

    // conditional branch taken / not taken
    set_entry(1, 0, 1, 5, 'h12);
    set_entry(5, 1, 0, 0, 'h16);
    comb = 1'b1;
    kick(0);
    foreach (m_ctx[k]) if (k < 3) begin
      step();
      check_eq("br_pc", obs_pc, (k == 2) ? 5 : k);
    end
    step();
    check_eq("br_cnt", obs_cnt, 3);
    check_eq("br_done", obs_done, 1);
    set_entry(2, 1, 0, 0, 'h13);
    comb = 1'b0;
    kick(0);
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("nbr_pc", obs_pc, k);
    end
    step();
    check_eq("nbr_cnt", obs_cnt, 3);

    // stall at PC=2 with a live branch
    set_entry(1, 0, 0, 0, 'h12);
    set_entry(2, 0, 1, 4, 'h13);
    set_entry(4, 1, 0, 0, 'h15);
    kick(0);
    step(); step();
    stall = 1'b1; comb = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      check_eq("st_en", obs_en, 0);
      check_eq("st_pc", obs_pc, 2);
    end
    stall = 1'b0; comb = 1'b0;
    step(); check_eq("st_pc_go", obs_pc, 2);
    step(); check_eq("st_pc_next", obs_pc, 3);
    step(); check_eq("st_cnt", obs_cnt, 4);

    // load/run interlock: pending write to the halt entry must not land mid-run
    kick(0);
    load_valid = 1'b1; load_addr = 3'd3; ld_halt = 1'b0; ld_br = 1'b0; ld_tgt = '0; ld_ctx = 16'hABCD;
    for (int k = 0; k < 4; k++) begin
      step();
      check_eq("lk_ready", obs_ready, 0);
    end
    check_eq("lk_ctx_kept", obs_ctx, 'h14);
    step();
    check_eq("lk_ready_done", obs_ready, 1);
    load_valid = 1'b0;
    start = 1'b1; start_addr = 3'd6;
    load_valid = 1'b1; load_addr = 3'd6; ld_halt = 1'b1; ld_ctx = 16'hBEEF;
    step();
    start = 1'b0; load_valid = 1'b0;
    step();
    check_eq("ls_ctx", obs_ctx, 'hBEEF);
    step();
    check_eq("ls_done", obs_done, 1);

    // wrap and abort
    set_entry(6, 0, 0, 0, 'h66);
    set_entry(7, 0, 0, 0, 'h77);
    kick(6);
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("wr_pc", obs_pc, (6 + k) % DEPTH);
    end
    abort = 1'b1;
    step();
    check_eq("wr_pc1", obs_pc, 1);
    abort = 1'b0;
    step();
    check_eq("ab_busy", obs_busy, 0);
    check_eq("ab_en", obs_en, 0);
    check_eq("ab_done", obs_done, 0);
    check_eq("ab_pc", obs_pc, 1);
    check_eq("ab_cnt", obs_cnt, 3);

    // reset mid-run, then replay
    set_entry(3, 1, 0, 0, 'h14);
    kick(0);
    step(); step(); step();
    rst = 1'b1;
    step();
    check_eq("rr_pc3", obs_pc, 3);
    rst = 1'b0;
    step();
    check_eq("rr_pc", obs_pc, 0);
    check_eq("rr_cnt", obs_cnt, 0);
    check_eq("rr_busy", obs_busy, 0);
    kick(0);
    for (int k = 0; k < 4; k++) begin
      step();
      check_eq("rr_ctx", obs_ctx, 'h11 + k);
    end

    // spin on self-target until the counter saturates
    set_entry(0, 0, 1, 0, 'h11);
    comb = 1'b1;
    kick(0);
    repeat (20) step();
    check_eq("sat_cnt", obs_cnt, CMAX);
    check_eq("sat_pc", obs_pc, 0);
    abort = 1'b1; step(); abort = 1'b0;

    // random traffic
    for (int n = 0; n < 2000; n++) begin
      rst        = ($urandom_range(0, 199) == 0);
      abort      = ($urandom_range(0, 39) == 0);
      start      = ($urandom_range(0, 9) == 0);
      stall      = ($urandom_range(0, 4) == 0);
      comb       = $urandom_range(0, 1);
      start_addr = AW'($urandom_range(0, DEPTH - 1));
      load_valid = ($urandom_range(0, 2) == 0);
      load_addr  = AW'($urandom_range(0, DEPTH - 1));
      ld_halt    = ($urandom_range(0, 5) == 0);
      ld_br      = ($urandom_range(0, 2) == 0);
      ld_tgt     = AW'($urandom_range(0, DEPTH - 1));
      ld_ctx     = CW'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pbox_context_sequencer.md
Name: pbox_context_sequencer

Overview:
- Drives the predication box's side of the interface: steps through a loadable context program and presents one context word plus enable per cycle.
- Consumes the box's combinational predicate result to take conditional jumps.
- Sits between the configuration loader and one predication box instance in each predication column of the array.

Parameters:
- CONTEXT_WIDTH, 16, width of the context word delivered to the predication box.
- ADDR_WIDTH, 6, program counter / context memory address width; depth = 2**ADDR_WIDTH.
- CNT_WIDTH, 16, width of the executed-cycle counter.

Ports:
- CLK_I  in  1  clock.
- RST_I  in  1  synchronous, active-high reset.
- LOAD_VALID_I  in  1  loader entry valid.
- LOAD_READY_O  out  1  sequencer accepts a load entry.
- LOAD_ADDR_I  in  ADDR_WIDTH  entry address.
- LOAD_DATA_I  in  CONTEXT_WIDTH+ADDR_WIDTH+2  entry = {halt, branch, target[ADDR_WIDTH], context[CONTEXT_WIDTH]}.
- START_I  in  1  start pulse.
- START_ADDR_I  in  ADDR_WIDTH  first program address.
- ABORT_I  in  1  terminate run, return to IDLE.
- STALL_I  in  1  freeze execution this cycle.
- PBOX_COMB_I  in  1  predicate result of the current context, from the predication box.
- CONTEXT_O  out  CONTEXT_WIDTH  context word to the predication box.
- EN_O  out  1  enable to the predication box.
- PC_O  out  ADDR_WIDTH  current program counter.
- BUSY_O  out  1  state == RUN.
- DONE_O  out  1  state == DONE.
- CYCLE_CNT_O  out  CNT_WIDTH  executed (enabled) cycles of the last/current run.

Behaviour:
- **Reset:** state IDLE, PC_O=0, CYCLE_CNT_O=0, DONE_O=0, BUSY_O=0. Context memory is not cleared.
- **States:** IDLE, RUN, DONE.
- **Load handshake:**
  - LOAD_READY_O = (state != RUN).
  - Write mem[LOAD_ADDR_I] <= LOAD_DATA_I on VALID && READY.
  - Loads while RUN stall the loader (READY=0); nothing is dropped.
- **Start:**
  - In IDLE or DONE, START_I → next cycle RUN, PC=START_ADDR_I, CYCLE_CNT=0, DONE_O=0.
  - START_I in RUN is ignored.
  - Load and start in the same cycle: the write lands and is visible to the first RUN cycle.
- **CONTEXT_O:** asynchronous read of the context field of mem[PC] while RUN; all-zero outside RUN.
- **EN_O:** RUN && !STALL_I (combinational).
- **RUN cycle with STALL_I=0 (entry e = mem[PC]):**
  - CYCLE_CNT increments, saturating at all-ones.
  - If e.halt: next state DONE, PC holds. Halt has priority over branch.
  - Else if e.branch && PBOX_COMB_I: PC <= e.target.
  - Else: PC <= PC+1, wrapping from 2**ADDR_WIDTH-1 to 0.
- **STALL_I=1 in RUN:** PC, counter and state hold; branch not evaluated; EN_O=0.
- **ABORT_I:**
  - In any state → IDLE next cycle; PC holds; counter holds.
  - ABORT_I beats STALL_I and START_I.
  - ABORT_I in IDLE has no effect.
- **DONE:** DONE_O=1 until START_I or ABORT_I; CYCLE_CNT_O holds the final count.
- **RST_I mid-run:** overrides everything; back to IDLE next cycle with the reset values; memory contents keep their values.
- **Branch predicate:** PBOX_COMB_I is sampled in the same cycle as the context that produced it (zero-latency loop through the box's combinational path).
  - Branch target equal to PC is legal (spin until the predicate clears).

Test Plan:
- **Straight-line run.** Load ctx 0x0011..0x0014 at addr 0..3, halt bit on addr 3; START_I, START_ADDR=0.
  - EN_O=1 for 4 cycles with CONTEXT_O 0x0011,0x0012,0x0013,0x0014.
  - Then DONE_O=1, CYCLE_CNT_O=4, CONTEXT_O=0.
- **Conditional branch.** addr 1 branch=1, target=5; addr 5 halt.
  - PBOX_COMB_I=1 at PC=1 → PC sequence 0,1,5, CYCLE_CNT=3.
  - With PBOX_COMB_I=0 (addr 2 halt) → 0,1,2.
- **Stall.** Assert STALL_I for 2 cycles at PC=2.
  - EN_O=0 and PC_O=2 held for those cycles; branch at addr 2 not taken during the stall even with PBOX_COMB_I=1.
  - CYCLE_CNT excludes the stalled cycles.
- **Load/run interlock.** Hold LOAD_VALID_I during RUN.
  - LOAD_READY_O=0 and memory unchanged.
  - After DONE the write completes in 1 cycle.
  - START_I together with a load to addr START_ADDR executes the new context in the first cycle.
- **Wrap and abort.** ADDR_WIDTH=3, START_ADDR=6, no halts.
  - PC 6,7,0,1; ABORT_I at PC=1 → IDLE next cycle, EN_O=0, BUSY_O=0, DONE_O=0.
- **Reset mid-run.** RST_I at PC=3.
  - Next cycle PC_O=0, CYCLE_CNT_O=0, IDLE.
  - A restart from addr 0 reproduces the pre-reset context contents.
